// File: rtl/eq3_pkg.sv
// Shared types and defaults for the bit-serial three-way equality checker.
package eq3_pkg;

    localparam int unsigned W_DEF     = 3;
    localparam int unsigned CNT_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StShift = 2'd1;
    localparam state_t StDone  = 2'd2;

    function automatic int unsigned idx_w(input int unsigned w);
        return $clog2(w);
    endfunction

    localparam int unsigned IDX_W = idx_w(W_DEF);

endpackage

// File: rtl/eq3_serial_checker_if.sv
// Serial input lines and result/statistics outputs of eq3_serial_checker.
interface eq3_serial_checker_if
    import eq3_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic                 start;
    logic                 abort;
    logic                 bit_valid;
    logic                 a_bit;
    logic                 b_bit;
    logic                 c_bit;
    logic                 busy;
    logic                 done;
    logic                 eq;
    logic [idx_w(W)-1:0]  mis_idx;
    logic [CNT_W-1:0]     frame_cnt;
    logic [CNT_W-1:0]     fail_cnt;

    modport master (
        output start, abort, bit_valid, a_bit, b_bit, c_bit,
        input  busy, done, eq, mis_idx, frame_cnt, fail_cnt
    );

    modport slave (
        input  start, abort, bit_valid, a_bit, b_bit, c_bit,
        output busy, done, eq, mis_idx, frame_cnt, fail_cnt
    );

endinterface

// File: rtl/eq3_bit_slice.sv
// Combinational 1-bit cell: high when all three input bits agree.
module eq3_bit_slice (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic match
);

    assign match = (a ~^ b) & (a ~^ c);

endmodule

// File: rtl/eq3_serial_checker.sv
// Bit-serial A = B = C checker, MSB first, with saturating frame/failure counters.
module eq3_serial_checker
    import eq3_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    eq3_serial_checker_if.slave   bus
);

    localparam int unsigned IdxW = idx_w(W);

    state_t            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic              run_eq_q, run_eq_d;
    logic [IdxW-1:0]   first_idx_q, first_idx_d;
    logic              done_q, done_d;
    logic              eq_q, eq_d;
    logic [IdxW-1:0]   mis_idx_q, mis_idx_d;
    logic [CNT_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]  fail_q, fail_d;

    logic              match;
    logic [IdxW-1:0]   cur_idx;
    logic              last_bit;

    eq3_bit_slice u_slice (
        .a     (bus.a_bit),
        .b     (bus.b_bit),
        .c     (bus.c_bit),
        .match (match)
    );

    assign cur_idx  = IdxW'(W - 1) - cnt_q;
    assign last_bit = (cnt_q == IdxW'(W - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        run_eq_d    = run_eq_q;
        first_idx_d = first_idx_q;
        done_d      = 1'b0;
        eq_d        = eq_q;
        mis_idx_d   = mis_idx_q;
        frame_d     = frame_q;
        fail_d      = fail_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d     = StShift;
                    cnt_d       = '0;
                    run_eq_d    = 1'b1;
                    first_idx_d = '0;
                end
            end
            StShift: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.bit_valid) begin
                    run_eq_d = run_eq_q & match;
                    if (run_eq_q && !match) begin
                        first_idx_d = cur_idx;
                    end
                    cnt_d = cnt_q + 1'b1;
                    // Result is committed on the final-bit edge so it is visible with done.
                    if (last_bit) begin
                        state_d   = StDone;
                        cnt_d     = '0;
                        done_d    = 1'b1;
                        eq_d      = run_eq_d;
                        mis_idx_d = run_eq_d ? '0 : first_idx_d;
                        if (frame_q != {CNT_W{1'b1}}) begin
                            frame_d = frame_q + 1'b1;
                        end
                        if (!run_eq_d && (fail_q != {CNT_W{1'b1}})) begin
                            fail_d = fail_q + 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            run_eq_q    <= 1'b1;
            first_idx_q <= '0;
            done_q      <= 1'b0;
            eq_q        <= 1'b0;
            mis_idx_q   <= '0;
            frame_q     <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_eq_q    <= run_eq_d;
            first_idx_q <= first_idx_d;
            done_q      <= done_d;
            eq_q        <= eq_d;
            mis_idx_q   <= mis_idx_d;
            frame_q     <= frame_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.eq        = eq_q;
    assign bus.mis_idx   = mis_idx_q;
    assign bus.frame_cnt = frame_q;
    assign bus.fail_cnt  = fail_q;

endmodule
